// File: rtl/unid_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// States, opcodes, ALU codes and datapath mux selects.
package unid_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_ADDR,
    S_MEM,
    S_MEMWB,
    S_BRANCH,
    S_JAL,
    S_ERROR
  } state_t;

  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_LW  = 7'd3;
  localparam logic [6:0] OP_I   = 7'd19;
  localparam logic [6:0] OP_B   = 7'd99;
  localparam logic [6:0] OP_JAL = 7'd111;
  localparam logic [6:0] OP_SW  = 7'd35;
  localparam logic [6:0] OP_LUI = 7'd55;

  localparam logic [6:0] F7_BASE = 7'd0;
  localparam logic [6:0] F7_ALT  = 7'd32;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS1   = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;
  localparam logic [1:0] WB_SLT    = 2'd3;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] wb_sel;
    logic       instr_done;
    logic       illegal;
    logic       bus_error;
  } ctrl_t;

endpackage

// File: rtl/unid_controle_multiciclo_alu_dec.sv
// R-type funct3/funct7 to ALU operation decoder.
// Flags encodings the core does not implement.
module alu_dec
  import unid_pkg::*;
(
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  output logic [3:0] alu_op,
  output logic       illegal
);

  // funct3 selects the operation; funct7 only splits add/sub
  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    unique case (f3)
      3'd0: begin
        if (f7 == F7_ALT) alu_op = ALU_SUB;
        else if (f7 != F7_BASE) illegal = 1'b1;
      end
      3'd1: alu_op = ALU_SLL;
      3'd2: alu_op = ALU_SUB;
      3'd3: illegal = 1'b1;
      3'd4: alu_op = ALU_XOR;
      3'd5: alu_op = ALU_SRL;
      3'd6: alu_op = ALU_OR;
      3'd7: alu_op = ALU_AND;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/unid_controle_multiciclo.sv
// Multi-cycle control FSM for the shared-ALU, shared-memory core.
// Memory waits are bounded; overrunning the bound parks in ERROR.
module unid_controle_multiciclo
  import unid_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] ALUOp,
  output logic [1:0] wb_sel,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_error
);

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       r_op;
  logic             r_ill;
  logic             taken, br_ok;
  ctrl_t            c, co;

  alu_dec u_alu_dec (
    .f3      (f3),
    .f7      (f7),
    .alu_op  (r_op),
    .illegal (r_ill)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Branch condition from funct3 and the ALU compare flags
  always_comb begin
    taken = 1'b0;
    br_ok = 1'b1;
    unique case (f3)
      3'd0: taken = zero;
      3'd1: taken = ~zero;
      3'd4: taken = neg;
      3'd5: taken = ~neg;
      default: br_ok = 1'b0;
    endcase
  end

  // Next state, wait counter and control word
  always_comb begin
    c       = '0;
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        if (mem_ready) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_d    = S_DECODE;
        end else if (cnt_inc == TO) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        case (opcode)
          OP_R, OP_I, OP_LUI: state_d = S_EXEC;
          OP_LW, OP_SW:       state_d = S_ADDR;
          OP_B:               state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          default: begin
            c.illegal = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        state_d = S_WB;
        if (opcode == OP_LUI) begin
          c.alu_src_a = SRCA_ZERO;
          c.alu_src_b = SRCB_IMM;
        end else if (opcode == OP_I) begin
          c.alu_src_a = SRCA_RS1;
          c.alu_src_b = SRCB_IMM;
        end else begin
          c.alu_src_a = SRCA_RS1;
          c.alu_src_b = SRCB_RS2;
          c.alu_op    = r_op;
          if (r_ill) begin
            c.illegal = 1'b1;
            state_d   = S_FETCH;
          end
        end
      end
      S_WB: begin
        c.reg_write  = 1'b1;
        c.wb_sel     = (opcode == OP_R && f3 == 3'd2)
                       ? WB_SLT : WB_ALUOUT;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      S_ADDR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        if (opcode == OP_LW && f3 != 3'd2) begin
          c.illegal = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        c.mem_we  = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            c.instr_done = 1'b1;
            state_d      = S_FETCH;
          end else begin
            state_d = S_MEMWB;
          end
        end else if (cnt_inc == TO) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.wb_sel     = WB_MEM;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALU_SUB;
        if (br_ok) begin
          c.pc_write   = taken;
          c.pc_src     = taken;
          c.instr_done = 1'b1;
        end else begin
          c.illegal = 1'b1;
        end
        state_d = S_FETCH;
      end
      S_JAL: begin
        c.reg_write  = 1'b1;
        c.wb_sel     = WB_PC;
        c.pc_write   = 1'b1;
        c.pc_src     = 1'b1;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      S_ERROR: c.bus_error = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset silences every output in the same cycle
  assign co = rst ? '0 : c;

  assign mem_req    = co.mem_req;
  assign mem_we     = co.mem_we;
  assign iord       = co.iord;
  assign ir_write   = co.ir_write;
  assign pc_write   = co.pc_write;
  assign pc_src     = co.pc_src;
  assign reg_write  = co.reg_write;
  assign alu_src_a  = co.alu_src_a;
  assign alu_src_b  = co.alu_src_b;
  assign ALUOp      = co.alu_op;
  assign wb_sel     = co.wb_sel;
  assign instr_done = co.instr_done;
  assign illegal    = co.illegal;
  assign bus_error  = co.bus_error;

  // State and wait counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_unid_controle_multiciclo.sv
// Self-checking bench for the multi-cycle control unit.
// Expected per-cycle controls come from an instruction-phase model.
module tb_unid_controle_multiciclo;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] alu;
    logic [1:0] wb;
    logic       done;
    logic       ill;
    logic       berr;
  } ov_t;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       zero, neg, mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic       reg_write, instr_done, illegal, bus_error;
  logic [1:0] alu_src_a, alu_src_b, wb_sel;
  logic [3:0] ALUOp;

  int  n_chk = 0;
  int  n_pass = 0;
  ov_t exp_q[$];
  bit  rdy_q[$];

  always #5 clk = ~clk;

  unid_controle_multiciclo #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .f3         (f3),
    .f7         (f7),
    .zero       (zero),
    .neg        (neg),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ALUOp      (ALUOp),
    .wb_sel     (wb_sel),
    .instr_done (instr_done),
    .illegal    (illegal),
    .bus_error  (bus_error)
  );

  function automatic ov_t obs();
    ov_t o;
    o.mem_req   = mem_req;
    o.mem_we    = mem_we;
    o.iord      = iord;
    o.ir_write  = ir_write;
    o.pc_write  = pc_write;
    o.pc_src    = pc_src;
    o.reg_write = reg_write;
    o.a         = alu_src_a;
    o.b         = alu_src_b;
    o.alu       = ALUOp;
    o.wb        = wb_sel;
    o.done      = instr_done;
    o.ill       = illegal;
    o.berr      = bus_error;
    return o;
  endfunction

  task automatic cyc(input bit rdy, output ov_t o);
    mem_ready = rdy;
    @(negedge clk);
    o = obs();
    @(posedge clk);
    #1;
  endtask

  function automatic ov_t mk(input logic [1:0] a, input logic [1:0] b,
                             input logic [3:0] alu);
    ov_t v = '0;
    v.a = a;
    v.b = b;
    v.alu = alu;
    return v;
  endfunction

  task automatic push(input ov_t v, input bit rdy);
    exp_q.push_back(v);
    rdy_q.push_back(rdy);
  endtask

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected control sequence for one whole instruction
  task automatic build(input logic [6:0] op, input logic [2:0] fn3,
                       input logic [6:0] fn7, input bit z, input bit n,
                       input int fw, input int mw);
    ov_t v;
    bit  bad, tk;
    exp_q.delete();
    rdy_q.delete();
    for (int i = 0; i <= fw; i++) begin
      v = mk(2'd0, 2'd1, 4'b0000);
      v.mem_req = 1'b1;
      if (i == fw) begin
        v.ir_write = 1'b1;
        v.pc_write = 1'b1;
      end
      push(v, i == fw);
    end
    v = mk(2'd2, 2'd2, 4'b0000);
    if (!(op inside {7'd51, 7'd19, 7'd55, 7'd3, 7'd35, 7'd99, 7'd111})) begin
      v.ill = 1'b1;
      push(v, rnd());
      return;
    end
    push(v, rnd());
    if (op == 7'd51 || op == 7'd19 || op == 7'd55) begin
      bad = 1'b0;
      if (op == 7'd55) v = mk(2'd3, 2'd2, 4'b0000);
      else if (op == 7'd19) v = mk(2'd1, 2'd2, 4'b0000);
      else begin
        v = mk(2'd1, 2'd0, 4'b0000);
        case (fn3)
          3'd0: if (fn7 == 7'd32) v.alu = 4'b0001;
                else if (fn7 != 7'd0) bad = 1'b1;
          3'd1: v.alu = 4'b0100;
          3'd2: v.alu = 4'b0001;
          3'd3: bad = 1'b1;
          3'd4: v.alu = 4'b0110;
          3'd5: v.alu = 4'b0101;
          3'd6: v.alu = 4'b0011;
          default: v.alu = 4'b0010;
        endcase
      end
      v.ill = bad;
      push(v, rnd());
      if (bad) return;
      v = '0;
      v.reg_write = 1'b1;
      v.wb = (op == 7'd51 && fn3 == 3'd2) ? 2'd3 : 2'd0;
      v.done = 1'b1;
      push(v, rnd());
    end else if (op == 7'd3 || op == 7'd35) begin
      v = mk(2'd1, 2'd2, 4'b0000);
      if (op == 7'd3 && fn3 != 3'd2) begin
        v.ill = 1'b1;
        push(v, rnd());
        return;
      end
      push(v, rnd());
      for (int i = 0; i <= mw; i++) begin
        v = '0;
        v.mem_req = 1'b1;
        v.iord = 1'b1;
        v.mem_we = (op == 7'd35);
        v.done = (op == 7'd35) && (i == mw);
        push(v, i == mw);
      end
      if (op == 7'd3) begin
        v = '0;
        v.reg_write = 1'b1;
        v.wb = 2'd1;
        v.done = 1'b1;
        push(v, rnd());
      end
    end else if (op == 7'd99) begin
      v = mk(2'd1, 2'd0, 4'b0001);
      bad = 1'b0;
      tk = 1'b0;
      case (fn3)
        3'd0: tk = z;
        3'd1: tk = !z;
        3'd4: tk = n;
        3'd5: tk = !n;
        default: bad = 1'b1;
      endcase
      if (bad) v.ill = 1'b1;
      else begin
        v.pc_write = tk;
        v.pc_src = tk;
        v.done = 1'b1;
      end
      push(v, rnd());
    end else begin
      v = '0;
      v.reg_write = 1'b1;
      v.wb = 2'd2;
      v.pc_write = 1'b1;
      v.pc_src = 1'b1;
      v.done = 1'b1;
      push(v, rnd());
    end
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] fn3,
                           input logic [6:0] fn7, input bit z, input bit n);
    opcode = op;
    f3 = fn3;
    f7 = fn7;
    zero = z;
    neg = n;
  endtask

  task automatic test_reset();
    ov_t o;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      opcode = 7'($urandom);
      cyc(1'b1, o);
      n_chk++;
      if (o !== ov_t'(0))
        $display("FAIL reset cyc %0d got %h exp 0", k, o);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    ov_t o;
    set_instr(7'd51, 3'd0, 7'd0, 1'b0, 1'b0);
    build(7'd51, 3'd0, 7'd0, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      cyc(1'b1, o);
      n_chk++;
      if (o !== exp_q[k])
        $display("FAIL add cyc %0d got %h exp %h", k, o, exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_lw_wait();
    ov_t o;
    set_instr(7'd3, 3'd2, 7'd0, 1'b0, 1'b0);
    build(7'd3, 3'd2, 7'd0, 1'b0, 1'b0, 0, 3);
    n_chk++;
    if (exp_q.size() != 8)
      $display("FAIL lw_len got %0d exp 8", exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      cyc(rdy_q[k], o);
      n_chk++;
      if (o !== exp_q[k])
        $display("FAIL lw cyc %0d got %h exp %h", k, o, exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    ov_t o;
    logic [2:0] fs[5] = '{3'd0, 3'd0, 3'd5, 3'd4, 3'd2};
    bit zs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bit ns[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int t = 0; t < 5; t++) begin
      set_instr(7'd99, fs[t], 7'd0, zs[t], ns[t]);
      build(7'd99, fs[t], 7'd0, zs[t], ns[t], 0, 0);
      for (int k = 0; k < exp_q.size(); k++) begin
        cyc(rdy_q[k], o);
        n_chk++;
        if (o !== exp_q[k])
          $display("FAIL branch%0d cyc %0d got %h exp %h",
                   t, k, o, exp_q[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_illegal();
    ov_t o;
    set_instr(7'h7F, 3'd0, 7'd0, 1'b0, 1'b0);
    build(7'h7F, 3'd0, 7'd0, 1'b0, 1'b0, 1, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      cyc(rdy_q[k], o);
      n_chk++;
      if (o !== exp_q[k])
        $display("FAIL illegal cyc %0d got %h exp %h", k, o, exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    ov_t o, v;
    set_instr(7'd51, 3'd0, 7'd0, 1'b0, 1'b0);
    exp_q.delete();
    rdy_q.delete();
    for (int i = 0; i < TO; i++) begin
      v = mk(2'd0, 2'd1, 4'b0000);
      v.mem_req = 1'b1;
      push(v, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      v = '0;
      v.berr = 1'b1;
      push(v, rnd());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      cyc(rdy_q[k], o);
      n_chk++;
      if (o !== exp_q[k])
        $display("FAIL fetch_to cyc %0d got %h exp %h", k, o, exp_q[k]);
      else n_pass++;
    end
    rst = 1'b1;
    cyc(1'b1, o);
    rst = 1'b0;
    n_chk++;
    if (o !== ov_t'(0)) $display("FAIL to_rst got %h exp 0", o);
    else n_pass++;
    set_instr(7'd35, 3'd2, 7'd0, 1'b0, 1'b0);
    build(7'd35, 3'd2, 7'd0, 1'b0, 1'b0, 0, TO - 1);
    rdy_q[rdy_q.size() - 1] = 1'b0;
    v = exp_q[exp_q.size() - 1];
    v.done = 1'b0;
    exp_q[exp_q.size() - 1] = v;
    v = '0;
    v.berr = 1'b1;
    push(v, 1'b1);
    push(v, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      cyc(rdy_q[k], o);
      n_chk++;
      if (o !== exp_q[k])
        $display("FAIL mem_to cyc %0d got %h exp %h", k, o, exp_q[k]);
      else n_pass++;
    end
    rst = 1'b1;
    cyc(1'b0, o);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_sw();
    ov_t o;
    set_instr(7'd35, 3'd2, 7'd0, 1'b0, 1'b0);
    build(7'd35, 3'd2, 7'd0, 1'b0, 1'b0, 0, 3);
    for (int k = 0; k < 4; k++) begin
      cyc(rdy_q[k], o);
      n_chk++;
      if (o !== exp_q[k])
        $display("FAIL sw_pre cyc %0d got %h exp %h", k, o, exp_q[k]);
      else n_pass++;
    end
    rst = 1'b1;
    cyc(1'b1, o);
    rst = 1'b0;
    n_chk++;
    if (o !== ov_t'(0)) $display("FAIL sw_rst got %h exp 0", o);
    else n_pass++;
    set_instr(7'd19, 3'd0, 7'd0, 1'b0, 1'b0);
    build(7'd19, 3'd0, 7'd0, 1'b0, 1'b0, 1, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      cyc(rdy_q[k], o);
      n_chk++;
      if (o !== exp_q[k])
        $display("FAIL sw_after cyc %0d got %h exp %h", k, o, exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    ov_t o;
    int ops[12] = '{51, 51, 19, 55, 3, 3, 35, 99, 99, 111, 127, 23};
    logic [6:0] op, fn7;
    logic [2:0] fn3;
    bit z, n;
    int fw, mw;
    for (int t = 0; t < 60; t++) begin
      op = 7'(ops[$urandom_range(0, 11)]);
      fn3 = 3'($urandom);
      if (op == 7'd3 && $urandom_range(0, 3) != 0) fn3 = 3'd2;
      case ($urandom_range(0, 2))
        0: fn7 = 7'd0;
        1: fn7 = 7'd32;
        default: fn7 = 7'($urandom);
      endcase
      z = rnd();
      n = rnd();
      fw = $urandom_range(0, TO - 1);
      mw = $urandom_range(0, TO - 1);
      set_instr(op, fn3, fn7, z, n);
      build(op, fn3, fn7, z, n, fw, mw);
      for (int k = 0; k < exp_q.size(); k++) begin
        cyc(rdy_q[k], o);
        n_chk++;
        if (o !== exp_q[k])
          $display("FAIL rand%0d op %0d cyc %0d got %h exp %h",
                   t, op, k, o, exp_q[k]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    set_instr(7'd0, 3'd0, 7'd0, 1'b0, 1'b0);
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid_sw();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
